// File: rtl/branch_predict_cu.sv
// Branch resolution and bimodal prediction for the pipelined RV32 core: resolves
// conditional branches in EX, trains a table of saturating counters, keeps statistics.

module branch_predict_cu_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] branch_sel,
    input  logic       mispredict
);

    // A branch can never be taken and a jump at the same time
    a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(branch_sel[0] && branch_sel[1]));

    // Jumps never flush as a misprediction
    a_jump_no_mispredict: assert property (@(posedge clk) disable iff (!rst_n)
        !(mispredict && branch_sel[1]));

endmodule

module branch_predict_cu #(
    parameter int unsigned XLEN        = 32'd32,
    parameter int unsigned BHT_ENTRIES = 32'd64,
    parameter int unsigned CTR_WIDTH   = 32'd2,
    parameter int unsigned INIT_CTR    = 32'd1,
    parameter int unsigned STAT_WIDTH  = 32'd16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  if_pred_taken,
    input  logic                  ex_valid,
    input  logic                  ex_branch,
    input  logic                  ex_jump,
    input  logic [2:0]            ex_func3,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic                  ex_pred_taken,
    input  logic                  ex_zf,
    input  logic                  ex_cf,
    input  logic                  ex_sf,
    input  logic                  ex_vf,
    output logic [1:0]            branch_sel,
    output logic                  mispredict,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] branch_cnt,
    output logic [STAT_WIDTH-1:0] mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CTR_WIDTH-1:0]  CTR_MAX_C  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0]  CTR_ZERO_C = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0]  CTR_INIT_C = CTR_WIDTH'(INIT_CTR);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX_C  = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0] STAT_ZERO_C = {STAT_WIDTH{1'b0}};

    // Two-way saturating step of a history counter
    function automatic logic [CTR_WIDTH-1:0] ctr_step(input logic [CTR_WIDTH-1:0] ctr,
                                                      input logic taken);
        logic [CTR_WIDTH-1:0] res;
        if (taken) begin
            if (ctr == CTR_MAX_C) res = ctr;
            else                  res = ctr + CTR_WIDTH'(1'b1);
        end else begin
            if (ctr == CTR_ZERO_C) res = ctr;
            else                   res = ctr - CTR_WIDTH'(1'b1);
        end
        return res;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping
    function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] cnt);
        logic [STAT_WIDTH-1:0] res;
        if (cnt == STAT_MAX_C) res = cnt;
        else                   res = cnt + STAT_WIDTH'(1'b1);
        return res;
    endfunction

    logic [CTR_WIDTH-1:0]  bht_r [BHT_ENTRIES];
    logic [IDX_W-1:0]      if_idx_s;
    logic [IDX_W-1:0]      ex_idx_s;
    logic                  cond_s;
    logic                  resolve_s;
    logic                  mispredict_s;
    logic [CTR_WIDTH-1:0]  bht_next_s;
    logic [STAT_WIDTH-1:0] branch_cnt_r;
    logic [STAT_WIDTH-1:0] mispredict_cnt_r;
    logic                  unused_pc_bits_s;

    assign if_idx_s = if_pc[IDX_W+1:2];
    assign ex_idx_s = ex_pc[IDX_W+1:2];
    // Word-offset and aliased upper PC bits do not take part in indexing
    assign unused_pc_bits_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                                ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    // Branch condition decode from func3 and ALU flags
    always_comb begin
        cond_s = 1'b0;
        case (ex_func3)
            3'd0:    cond_s = ex_zf;
            3'd1:    cond_s = ~ex_zf;
            3'd4:    cond_s = ex_sf ^ ex_vf;
            3'd5:    cond_s = ~(ex_sf ^ ex_vf);
            3'd6:    cond_s = ~ex_cf;
            3'd7:    cond_s = ex_cf;
            default: cond_s = 1'b0;
        endcase
    end

    // Resolution, outputs to the pipeline and the trained counter value
    always_comb begin
        resolve_s     = ex_valid & ex_branch & ~ex_jump;
        mispredict_s  = resolve_s & (cond_s ^ ex_pred_taken);
        bht_next_s    = ctr_step(bht_r[ex_idx_s], cond_s);
        branch_sel    = {ex_valid & ex_jump, resolve_s & cond_s};
        mispredict    = mispredict_s;
        if_pred_taken = bht_r[if_idx_s][CTR_WIDTH-1];
    end

    // History table: fetch reads the pre-update value, there is no bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 32'sd0; i < int'(BHT_ENTRIES); i++) begin
                bht_r[i] <= CTR_INIT_C;
            end
        end else if (resolve_s) begin
            bht_r[ex_idx_s] <= bht_next_s;
        end
    end

    // Statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_r     <= STAT_ZERO_C;
            mispredict_cnt_r <= STAT_ZERO_C;
        end else if (stat_clr) begin
            branch_cnt_r     <= STAT_ZERO_C;
            mispredict_cnt_r <= STAT_ZERO_C;
        end else if (resolve_s) begin
            branch_cnt_r <= stat_inc(branch_cnt_r);
            if (mispredict_s) begin
                mispredict_cnt_r <= stat_inc(mispredict_cnt_r);
            end
        end
    end

    assign branch_cnt     = branch_cnt_r;
    assign mispredict_cnt = mispredict_cnt_r;

    branch_predict_cu_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .branch_sel (branch_sel),
        .mispredict (mispredict)
    );

endmodule

// File: tb/tb_branch_predict_cu.sv
// Directed bench for branch_predict_cu with narrow (4-bit) statistics counters.

module tb_branch_predict_cu;

    localparam int unsigned SW = 32'd4;

    logic          clk;
    logic          rst_n;
    logic [31:0]   if_pc;
    logic          if_pred_taken;
    logic          ex_valid;
    logic          ex_branch;
    logic          ex_jump;
    logic [2:0]    ex_func3;
    logic [31:0]   ex_pc;
    logic          ex_pred_taken;
    logic          ex_zf;
    logic          ex_cf;
    logic          ex_sf;
    logic          ex_vf;
    logic [1:0]    branch_sel;
    logic          mispredict;
    logic          stat_clr;
    logic [SW-1:0] branch_cnt;
    logic [SW-1:0] mispredict_cnt;

    int vec_cnt;
    int err_cnt;
    logic [7:0] sweep_exp;
    logic [31:0] exp_cnt;

    branch_predict_cu #(
        .STAT_WIDTH (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_func3       (ex_func3),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_zf          (ex_zf),
        .ex_cf          (ex_cf),
        .ex_sf          (ex_sf),
        .ex_vf          (ex_vf),
        .branch_sel     (branch_sel),
        .mispredict     (mispredict),
        .stat_clr       (stat_clr),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic b, input logic j, input logic [2:0] f3,
                            input logic [31:0] pc, input logic pred);
        ex_valid      = v;
        ex_branch     = b;
        ex_jump       = j;
        ex_func3      = f3;
        ex_pc         = pc;
        ex_pred_taken = pred;
    endtask

    task automatic drive_flags(input logic zf, input logic cf, input logic sf, input logic vf);
        ex_zf = zf;
        ex_cf = cf;
        ex_sf = sf;
        ex_vf = vf;
    endtask

    // Directed sequence
    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        stat_clr = 1'b0;
        if_pc    = 32'h0;
        drive_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        drive_flags(1'b0, 1'b0, 1'b0, 1'b0);

        #2;
        check_eq("rst_pred_0x0", {31'd0, if_pred_taken}, 32'd0);
        if_pc = 32'hFC;
        #1;
        check_eq("rst_pred_0xfc", {31'd0, if_pred_taken}, 32'd0);
        check_eq("rst_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        check_eq("rst_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd0);
        check_eq("rst_branch_sel", {30'd0, branch_sel}, 32'd0);
        check_eq("rst_mispredict", {31'd0, mispredict}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Training: BEQ at 0x40 taken three times, counter 1->2->3->3
        tick();
        if_pc = 32'h40;
        drive_flags(1'b1, 1'b0, 1'b0, 1'b0);
        drive_ex(1'b1, 1'b1, 1'b0, 3'd0, 32'h40, 1'b0);
        #1;
        check_eq("train_c1_mispredict", {31'd0, mispredict}, 32'd1);
        check_eq("train_c1_sel", {30'd0, branch_sel}, 32'd1);
        check_eq("train_c1_pred", {31'd0, if_pred_taken}, 32'd0);
        tick();
        check_eq("train_c2_pred", {31'd0, if_pred_taken}, 32'd1);
        tick();
        check_eq("train_c3_pred", {31'd0, if_pred_taken}, 32'd1);
        tick();
        ex_valid = 1'b0;
        #1;
        check_eq("train_sat_pred", {31'd0, if_pred_taken}, 32'd1);
        check_eq("train_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        check_eq("train_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd3);

        // Two not-taken BNEs walk the saturated counter 3->2->1
        drive_ex(1'b1, 1'b1, 1'b0, 3'd1, 32'h40, 1'b0);
        #1;
        check_eq("nt_mispredict", {31'd0, mispredict}, 32'd0);
        tick();
        check_eq("nt1_pred", {31'd0, if_pred_taken}, 32'd1);
        tick();
        ex_valid = 1'b0;
        #1;
        check_eq("nt2_pred", {31'd0, if_pred_taken}, 32'd0);
        check_eq("nt_branch_cnt", {28'd0, branch_cnt}, 32'd5);
        check_eq("nt_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd3);

        // func3 sweep with sf=1 vf=0 cf=1 zf=0, predicting taken
        sweep_exp = 8'b1001_0010;
        drive_flags(1'b0, 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++) begin
            drive_ex(1'b1, 1'b1, 1'b0, 3'(f), 32'h80, 1'b1);
            #1;
            check_eq($sformatf("sweep_sel_f%0d", f), {30'd0, branch_sel}, {31'd0, sweep_exp[f]});
            check_eq($sformatf("sweep_mp_f%0d", f), {31'd0, mispredict}, {31'd0, ~sweep_exp[f]});
            tick();
        end

        ex_valid = 1'b0;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1;
        check_eq("clr_branch_cnt", {28'd0, branch_cnt}, 32'd0);

        // Jump that also claims to be a branch: jump only, no training, no stats
        drive_flags(1'b1, 1'b0, 1'b0, 1'b0);
        drive_ex(1'b1, 1'b1, 1'b1, 3'd0, 32'h40, 1'b0);
        #1;
        check_eq("jump_sel", {30'd0, branch_sel}, 32'd2);
        check_eq("jump_mispredict", {31'd0, mispredict}, 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        check_eq("jump_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        check_eq("jump_bht_0x40", {31'd0, if_pred_taken}, 32'd0);

        // Same-index fetch and update: fetch sees old value this cycle
        if_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 1'b0, 3'd0, 32'h100, 1'b0);
        #1;
        check_eq("coll_same_cycle", {31'd0, if_pred_taken}, 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        check_eq("coll_next_cycle", {31'd0, if_pred_taken}, 32'd1);
        if_pc = 32'h200;
        #1;
        check_eq("alias_0x200", {31'd0, if_pred_taken}, 32'd1);
        if_pc = 32'h0;
        #1;
        check_eq("alias_0x0", {31'd0, if_pred_taken}, 32'd1);

        // Statistics saturation with 20 mispredicting resolves
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        if_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 1'b0, 3'd0, 32'h300, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_cnt = (n > 15) ? 32'd15 : 32'(n);
            if (n == 14 || n == 15 || n == 20) begin
                check_eq($sformatf("sat_branch_n%0d", n), {28'd0, branch_cnt}, exp_cnt);
                check_eq($sformatf("sat_mp_n%0d", n), {28'd0, mispredict_cnt}, exp_cnt);
            end
        end

        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1;
        check_eq("clr_prio_branch", {28'd0, branch_cnt}, 32'd0);
        check_eq("clr_prio_mp", {28'd0, mispredict_cnt}, 32'd0);
        tick();
        tick();
        check_eq("burst_branch_cnt", {28'd0, branch_cnt}, 32'd2);
        check_eq("burst_pred_0x100", {31'd0, if_pred_taken}, 32'd1);

        // Asynchronous reset in the middle of the burst
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        check_eq("mid_rst_mp_cnt", {28'd0, mispredict_cnt}, 32'd0);
        check_eq("mid_rst_pred_0x100", {31'd0, if_pred_taken}, 32'd0);
        tick();
        check_eq("mid_rst_hold_cnt", {28'd0, branch_cnt}, 32'd0);
        check_eq("mid_rst_hold_pred", {31'd0, if_pred_taken}, 32'd0);
        ex_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
